dest_scoreboard: RTL and testbench
==================================

# dest_scoreboard

Destination-register scoreboard for the pipelined datapath. It sits at the consuming end of the 5-bit destination-select path. Issue marks the selected destination register (rt or rd) as pending. Writeback retires it. Source-operand lookups raise hazard flags that decode uses to stall. It tracks up to 2^CNT_W−1 outstanding writes per architectural register, and register 0 is never tracked.

## Interface
- CNT_W, default 2: per-register pending-counter width; max outstanding writes per register = 2^CNT_W−1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- issue_valid  input  1  decode presents an instruction that writes issue_dest.
- issue_dest  input  5  destination register number.
- issue_ready  output  1  scoreboard can accept the issue this cycle.
- wb_valid  input  1  writeback retires one write to wb_dest.
- wb_dest  input  5  retiring destination register number.
- src_a, src_b  input  5 each  source registers being decoded.
- hazard_a, hazard_b  output  1 each  source has a pending write.
- busy_any  output  1  registered; some register has a pending write.
- err_underflow  output  1  registered, sticky; writeback hit a register with no pending write.

## Operation
- State: 31 counters cnt[1..31], each CNT_W bits wide. There is no counter for register 0.
- Issue is accepted (fire) when issue_valid && issue_ready.
- Writeback is effective when wb_valid && wb_dest != 0 && cnt[wb_dest] != 0.
- Per-register update each edge, for register r != 0:
  - fire to r only: cnt+1.
  - effective wb to r only: cnt−1.
  - both in the same cycle: unchanged.
  - otherwise: hold.
- Counters never wrap. Saturation is prevented by issue_ready; underflow is prevented by the effective-wb rule.
- issue_ready is combinational:
  - 1 if issue_dest == 0.
  - Otherwise 1 if cnt[issue_dest] < max.
  - Otherwise 1 if effective wb to the same register this cycle.
  - Else 0.
- An issue with issue_dest 0 fires and changes no state.
- hazard_x is combinational: (src_x != 0) && (cnt[src_x] != 0). Subject to the bypass under Configuration.
- A same-cycle issue to src_x does not raise hazard_x. The new pending write becomes visible from the next cycle.
- busy_any is registered from the post-update counter values. It equals 1 iff any counter is non-zero after the edge.
- err_underflow is set on the edge after wb_valid && wb_dest != 0 && cnt[wb_dest] == 0. It stays set until reset.
- wb_valid with wb_dest 0 is ignored and does not raise the error.

## Timing
- Reset (rst_n low at an edge):
  - all counters 0, busy_any 0, err_underflow 0.
  - hence issue_ready 1 and hazard_a/hazard_b 0 once inputs settle.
- Reset has priority over a same-cycle issue or writeback. Pending state is discarded mid-operation.
- Issue-to-hazard latency: 1 cycle.
- Writeback-to-hazard-clear latency: 1 cycle without bypass, 0 with bypass.
- busy_any reflects state 1 cycle after the causing event.
- All outputs derive from registered state plus current inputs. There are no combinational paths from issue_valid to issue_ready.

## Configuration
- SB_WB_BYPASS_EN defined:
  - hazard_x is additionally masked when wb_valid && wb_dest == src_x && cnt[src_x] == 1, i.e. the last pending write retires this cycle.
  - Decode can then proceed in the writeback cycle, relying on register-file write-through.
- Undefined: hazard depends on counter state only, and the stall lasts until the cycle after writeback.

## Test plan
- Reset then idle:
  - rst_n=0 for 2 cycles with issue_valid=1, issue_dest=5 → cnt[5]=0, busy_any=0, err_underflow=0, issue_ready=1.
- Basic issue/retire:
  - issue dest 8 at cycle 0 → at cycle 1 hazard_a=1 for src_a=8 and busy_any=1.
  - wb 8 at cycle 3 → hazard_a=0 at cycle 4 (at cycle 3 with SB_WB_BYPASS_EN), busy_any=0 at cycle 4.
- Saturation:
  - three issues to register 12 (CNT_W=2) → issue_ready=0 for issue_dest=12.
  - adding wb_valid to 12 in the same cycle → issue_ready=1, and cnt stays 3 after the edge.
- Register 0:
  - issue dest 0 and src_a=0 → issue_ready=1, hazard_a=0, busy_any stays 0.
  - wb dest 0 → err_underflow stays 0.
- Underflow:
  - wb_valid with wb_dest=17 while cnt[17]=0 → err_underflow=1 next cycle and held.
  - cnt[17] stays 0, and only reset clears the flag.
- Simultaneous different registers:
  - issue 3 and wb 4 (cnt[4]=1) in one cycle → next cycle cnt[3]=1, cnt[4]=0, hazard on src 3 only.

Source files
------------

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard: per-register pending-write counters with hazard lookup.
// Optional macro SB_WB_BYPASS_EN masks a source hazard when its last pending write retires this cycle.
module dest_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [4:0] issue_dest,
    output logic       issue_ready,
    input  logic       wb_valid,
    input  logic [4:0] wb_dest,
    input  logic [4:0] src_a,
    input  logic [4:0] src_b,
    output logic       hazard_a,
    output logic       hazard_b,
    output logic       busy_any,
    output logic       err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q  [1:31];
    logic [CNT_W-1:0] cnt_d  [1:31];
    logic [CNT_W-1:0] cnt_rd [32];

    logic wb_live;
    logic wb_eff;
    logic wb_under;
    logic fire;
    logic busy_d;
    logic last_a;
    logic last_b;

    // Register 0 has no storage; reading it always yields an idle counter.
    always_comb begin
        cnt_rd[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_rd[r] = cnt_q[r];
        end
    end

    assign wb_live  = wb_valid && (wb_dest != 5'd0);
    assign wb_eff   = wb_live && (cnt_rd[wb_dest] != '0);
    assign wb_under = wb_live && (cnt_rd[wb_dest] == '0);

    // Deliberately independent of issue_valid so decode can use it to form its own valid.
    assign issue_ready = (issue_dest == 5'd0)
                      || (cnt_rd[issue_dest] != CNT_MAX)
                      || (wb_eff && (wb_dest == issue_dest));

    assign fire = issue_valid && issue_ready;

`ifdef SB_WB_BYPASS_EN
    assign last_a = wb_valid && (wb_dest == src_a) && (cnt_rd[src_a] == CNT_ONE);
    assign last_b = wb_valid && (wb_dest == src_b) && (cnt_rd[src_b] == CNT_ONE);
`else
    assign last_a = 1'b0;
    assign last_b = 1'b0;
`endif

    assign hazard_a = (src_a != 5'd0) && (cnt_rd[src_a] != '0) && !last_a;
    assign hazard_b = (src_b != 5'd0) && (cnt_rd[src_b] != '0) && !last_b;

    // NOTE: every variable written here gets its default first, so no path leaves a latch.
    always_comb begin
        busy_d = 1'b0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (fire && (issue_dest == 5'(r)) && !(wb_eff && (wb_dest == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wb_eff && (wb_dest == 5'(r)) && !(fire && (issue_dest == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
            busy_d = busy_d || (cnt_d[r] != '0);
        end
    end

    // NOTE: the counter array is explicitly cleared on reset because pending state must be
    // discarded; non-blocking assignments keep all counters updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            busy_any      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_any      <= busy_d;
            err_underflow <= err_underflow || wb_under;
        end
    end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Self-checking bench for dest_scoreboard: directed vector table, hand sequences and a
// randomized run against a counting reference model. Honours SB_WB_BYPASS_EN if defined.
module tb_dest_scoreboard;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] issue_dest;
    logic       issue_ready;
    logic       wb_valid;
    logic [4:0] wb_dest;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       hazard_a;
    logic       hazard_b;
    logic       busy_any;
    logic       err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    dest_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_dest    (issue_dest),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .src_a         (src_a),
        .src_b         (src_b),
        .hazard_a      (hazard_a),
        .hazard_b      (hazard_b),
        .busy_any      (busy_any),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       iv;
        bit [4:0] id;
        bit       wv;
        bit [4:0] wd;
        bit [4:0] sa;
        bit [4:0] sb;
        bit       e_ready;
        bit       e_ha;
        bit       e_hb;
        bit       e_busy;
        bit       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input bit [4:0] id, input bit wv, input bit [4:0] wd,
                         input bit [4:0] sa, input bit [4:0] sb);
        @(negedge clk);
        issue_valid = iv;
        issue_dest  = id;
        wb_valid    = wv;
        wb_dest     = wd;
        src_a       = sa;
        src_b       = sb;
        #1;
    endtask

    // Reference model: plain per-register outstanding-write counts.
    int  pend[32];
    bit  m_err;

    function automatic bit m_ready(input int d, input bit wv, input int wd);
        return (d == 0) || (pend[d] < CNT_MAX) || (wv && wd == d && pend[d] > 0);
    endfunction

    function automatic bit m_hazard(input int s, input bit wv, input int wd);
        if (s == 0 || pend[s] == 0) return 1'b0;
        if (BYP && wv && wd == s && pend[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy();
        for (int r = 1; r < 32; r++) if (pend[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_dest = '0; wb_valid = 1'b0; wb_dest = '0; src_a = '0; src_b = '0;

        // Reset with an issue pending on the inputs: it must be ignored.
        drive(1, 5'd5, 0, 0, 5'd5, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue_valid = 1'b0;
        #1;
        check("reset_ready_5", issue_ready, 1'b1);
        check("reset_hazard_5", hazard_a, 1'b0);
        check("reset_busy", busy_any, 1'b0);
        check("reset_err", err_underflow, 1'b0);

        //             iv id  wv wd  sa  sb  rdy ha    hb    busy err
        vecs.push_back('{1, 8,  0, 0,  8,  0,  1, 0,    0,    1, 0});  // issue 8, not visible yet
        vecs.push_back('{0, 8,  0, 0,  8,  0,  1, 1,    0,    1, 0});
        vecs.push_back('{0, 8,  0, 0,  8,  0,  1, 1,    0,    1, 0});
        vecs.push_back('{0, 0,  1, 8,  8,  0,  1, ~BYP, 0,    0, 0});  // retire 8
        vecs.push_back('{0, 0,  0, 0,  8,  0,  1, 0,    0,    0, 0});
        vecs.push_back('{1, 12, 0, 0, 12,  0,  1, 0,    0,    1, 0});  // fill 12
        vecs.push_back('{1, 12, 0, 0, 12,  0,  1, 1,    0,    1, 0});
        vecs.push_back('{1, 12, 0, 0, 12,  0,  1, 1,    0,    1, 0});
        vecs.push_back('{1, 12, 0, 0, 12,  0,  0, 1,    0,    1, 0});  // saturated
        vecs.push_back('{1, 12, 1, 12, 12, 0,  1, 1,    0,    1, 0});  // issue+wb, stays 3
        vecs.push_back('{1, 12, 0, 0, 12,  0,  0, 1,    0,    1, 0});  // still 3
        vecs.push_back('{0, 12, 1, 12, 0,  0,  1, 0,    0,    1, 0});  // 3 -> 2
        vecs.push_back('{0, 12, 1, 12, 0,  0,  1, 0,    0,    1, 0});  // 2 -> 1
        vecs.push_back('{0, 0,  1, 12, 12, 0,  1, ~BYP, 0,    0, 0});  // 1 -> 0
        vecs.push_back('{0, 0,  0, 0,  12, 0,  1, 0,    0,    0, 0});
        vecs.push_back('{1, 0,  0, 0,  0,  0,  1, 0,    0,    0, 0});  // register 0 issue
        vecs.push_back('{0, 0,  1, 0,  0,  0,  1, 0,    0,    0, 0});  // register 0 wb
        vecs.push_back('{1, 4,  0, 0,  0,  0,  1, 0,    0,    1, 0});
        vecs.push_back('{1, 3,  1, 4,  3,  4,  1, 0,    ~BYP, 1, 0});  // issue 3, retire 4
        vecs.push_back('{0, 0,  0, 0,  3,  4,  1, 1,    0,    1, 0});
        vecs.push_back('{0, 0,  1, 3,  3,  0,  1, ~BYP, 0,    0, 0});
        vecs.push_back('{0, 0,  1, 17, 0, 17,  1, 0,    0,    0, 1});  // underflow
        vecs.push_back('{0, 0,  0, 0,  0, 17,  1, 0,    0,    0, 1});  // sticky
        vecs.push_back('{0, 17, 0, 0,  0, 17,  1, 0,    0,    0, 1});  // cnt[17] still 0

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].wv, vecs[i].wd, vecs[i].sa, vecs[i].sb);
            check($sformatf("vec%0d_ready", i), issue_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_hazard_a", i), hazard_a, vecs[i].e_ha);
            check($sformatf("vec%0d_hazard_b", i), hazard_b, vecs[i].e_hb);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_busy", i), busy_any, vecs[i].e_busy);
            check($sformatf("vec%0d_err", i), err_underflow, vecs[i].e_err);
        end

        // Reset in the middle of activity discards pending writes and clears the error.
        drive(1, 9, 0, 0, 9, 0);
        @(posedge clk);
        drive(1, 9, 0, 0, 9, 0);
        @(posedge clk);
        #1;
        check("pre_reset_busy", busy_any, 1'b1);
        drive(1, 9, 1, 9, 9, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_busy", busy_any, 1'b0);
        check("mid_reset_err", err_underflow, 1'b0);
        drive(0, 9, 0, 0, 9, 0);
        rst_n = 1'b1;
        #1;
        check("mid_reset_hazard", hazard_a, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_busy", busy_any, 1'b0);

        // Randomized run against the model; narrow register range forces collisions and saturation.
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit iv, wv, do_rst, fire_m;
            int id, wd, sa, sb;
            iv = ($urandom_range(0, 99) < 55);
            wv = ($urandom_range(0, 99) < 45);
            id = $urandom_range(0, 5);
            wd = $urandom_range(0, 5);
            sa = $urandom_range(0, 6);
            sb = $urandom_range(0, 6);
            do_rst = ($urandom_range(0, 199) == 0);
            drive(iv, 5'(id), wv, 5'(wd), 5'(sa), 5'(sb));
            rst_n = !do_rst;
            #1;
            check("rnd_ready", issue_ready, m_ready(id, wv, wd));
            check("rnd_hazard_a", hazard_a, m_hazard(sa, wv, wd));
            check("rnd_hazard_b", hazard_b, m_hazard(sb, wv, wd));
            fire_m = iv && m_ready(id, wv, wd);
            if (do_rst) begin
                for (int r = 0; r < 32; r++) pend[r] = 0;
                m_err = 1'b0;
            end else begin
                if (wv && wd != 0 && pend[wd] == 0) m_err = 1'b1;
                if (wv && wd != 0 && pend[wd] > 0) pend[wd]--;
                if (fire_m && id != 0) pend[id]++;
            end
            @(posedge clk);
            #1;
            check("rnd_busy", busy_any, m_busy());
            check("rnd_err", err_underflow, m_err);
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
